// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port, variable-latency word memory
// between instruction fetch and the memory-access stage. One transaction is
// in flight at a time, data wins over fetch, and the freeze outputs hold the
// pipeline until the owning access completes. A branch flush that lands on an
// in-flight fetch lets the read finish but throws its data away.
module imem_dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // fetch stage
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_freeze,
    // memory stage
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_freeze,
    // shared memory port
    output logic              sram_req,
    output logic              sram_we,
    output logic [ADDR_W-3:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_FETCH,
        S_FDROP,
        S_DDONE,
        S_FDONE
    } state_t;

    state_t             r_state;
    logic               r_sram_req;
    logic               r_sram_we;
    logic [ADDR_W-3:0]  r_sram_addr;
    logic [DATA_W-1:0]  r_sram_wdata;
    logic [DATA_W-1:0]  r_if_inst;
    logic [DATA_W-1:0]  r_mem_rdata;

    logic               w_mem_req;
    logic               w_mem_freeze;
    logic               w_if_freeze;
    // Byte-offset bits are dropped: both requesters are word-aligned.
    logic               w_unused;

    assign w_unused = ^{if_addr[1:0], mem_addr[1:0]};

    // Freeze is released only in the single DONE cycle of the owner's access.
    assign w_mem_req    = mem_rd_en | mem_wr_en;
    assign w_mem_freeze = w_mem_req & (r_state != S_DDONE);
    assign w_if_freeze  = w_mem_freeze | (if_req & (r_state != S_FDONE));

    // Sequencer: issues one latched transaction at a time and captures results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sram_req   <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_if_inst    <= '0;
            r_mem_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_req) begin
                        r_sram_req   <= 1'b1;
                        r_sram_we    <= mem_wr_en;
                        r_sram_addr  <= mem_addr[ADDR_W-1:2];
                        r_sram_wdata <= mem_wdata;
                        r_state      <= S_DATA;
                    end else if (if_req && !flush) begin
                        r_sram_req   <= 1'b1;
                        r_sram_we    <= 1'b0;
                        r_sram_addr  <= if_addr[ADDR_W-1:2];
                        r_sram_wdata <= '0;
                        r_state      <= S_FETCH;
                    end
                end
                S_DATA: begin
                    if (sram_ready) begin
                        if (!r_sram_we)
                            r_mem_rdata <= sram_rdata;
                        r_sram_req <= 1'b0;
                        r_state    <= S_DDONE;
                    end
                end
                S_FETCH: begin
                    // Completion wins over a same-cycle flush; the fetch stage
                    // then loads the branch target rather than PC+4.
                    if (sram_ready) begin
                        r_if_inst  <= sram_rdata;
                        r_sram_req <= 1'b0;
                        r_state    <= S_FDONE;
                    end else if (flush) begin
                        r_state <= S_FDROP;
                    end
                end
                S_FDROP: begin
                    // Stale read still runs to completion; its data is ignored.
                    if (sram_ready) begin
                        r_sram_req <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                S_DDONE: r_state <= S_IDLE;
                S_FDONE: r_state <= S_IDLE;
                default: begin
                    r_sram_req <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign sram_req   = r_sram_req;
    assign sram_we    = r_sram_we;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;
    assign if_inst    = r_if_inst;
    assign mem_rdata  = r_mem_rdata;
    assign if_freeze  = w_if_freeze;
    assign mem_freeze = w_mem_freeze;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with a wait-state memory responder.
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        flush;
    logic [31:0] if_inst;
    logic        if_freeze;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_freeze;
    logic        sram_req;
    logic        sram_we;
    logic [29:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;

    int n_checks = 0;
    int n_errors = 0;
    int mem_wait = 0;
    logic [31:0] mem [0:255];

    imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .flush(flush),
        .if_inst(if_inst), .if_freeze(if_freeze),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_freeze(mem_freeze),
        .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled at posedge+3.
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Memory responder: ready pulses after mem_wait cycles of sram_req.
    initial begin
        int cnt;
        cnt = 0;
        sram_ready = 1'b0;
        sram_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (sram_ready || !sram_req) begin
                sram_ready = 1'b0;
                cnt = 0;
            end else if (cnt == mem_wait) begin
                sram_ready = 1'b1;
                sram_rdata = mem[sram_addr[7:0]];
            end else begin
                cnt++;
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + i;
        mem[2] = 32'hE3A0_0014;

        rst = 1'b1; if_req = 0; if_addr = 0; flush = 0;
        mem_rd_en = 0; mem_wr_en = 0; mem_addr = 0; mem_wdata = 0;
        tick(); tick();
        chk("rst_sram_req", {31'd0, sram_req}, 32'd0);
        chk("rst_sram_addr", {2'd0, sram_addr}, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_freeze", {30'd0, if_freeze, mem_freeze}, 32'd0);
        rst = 1'b0;
        tick();

        // Fetch with 2 wait states: freeze 4 cycles, then FDONE.
        mem_wait = 2; if_req = 1; if_addr = 32'h8;
        #1;
        chk("f1_freeze_T", {31'd0, if_freeze}, 32'd1);
        tick();
        chk("f1_req", {31'd0, sram_req}, 32'd1);
        chk("f1_addr", {2'd0, sram_addr}, 32'h2);
        chk("f1_we", {31'd0, sram_we}, 32'd0);
        chk("f1_freeze_T1", {31'd0, if_freeze}, 32'd1);
        tick(); chk("f1_freeze_T2", {31'd0, if_freeze}, 32'd1);
        tick(); chk("f1_freeze_T3", {31'd0, if_freeze}, 32'd1);
        tick();
        chk("f1_freeze_T4", {31'd0, if_freeze}, 32'd0);
        chk("f1_inst", if_inst, 32'hE3A0_0014);
        if_req = 0;
        tick();

        // Load and fetch collide: data first, fetch after.
        mem_wait = 1; mem_rd_en = 1; mem_addr = 32'h100; if_req = 1; if_addr = 32'h20;
        #1;
        chk("c_mfreeze_T", {31'd0, mem_freeze}, 32'd1);
        chk("c_ifreeze_T", {31'd0, if_freeze}, 32'd1);
        tick();
        chk("c_data_req", {31'd0, sram_req}, 32'd1);
        chk("c_data_addr", {2'd0, sram_addr}, 32'h40);
        chk("c_data_we", {31'd0, sram_we}, 32'd0);
        tick(); chk("c_ifreeze_T2", {31'd0, if_freeze}, 32'd1);
        tick();
        chk("c_ddone_mfreeze", {31'd0, mem_freeze}, 32'd0);
        chk("c_ddone_ifreeze", {31'd0, if_freeze}, 32'd1);
        chk("c_rdata", mem_rdata, 32'hC0DE_0040);
        mem_rd_en = 0;
        tick();
        chk("c_idle_ifreeze", {31'd0, if_freeze}, 32'd1);
        chk("c_idle_gap", {31'd0, sram_req}, 32'd0);
        tick();
        chk("c_fetch_addr", {2'd0, sram_addr}, 32'h8);
        chk("c_fetch_ifreeze", {31'd0, if_freeze}, 32'd1);
        tick(); tick();
        chk("c_fdone_ifreeze", {31'd0, if_freeze}, 32'd0);
        chk("c_inst", if_inst, 32'hC0DE_0008);
        if_req = 0;
        tick();

        // Store: write fields held for the whole transaction.
        mem_wait = 1; mem_wr_en = 1; mem_addr = 32'h4; mem_wdata = 32'h1234;
        tick();
        chk("s_we_T1", {31'd0, sram_we}, 32'd1);
        chk("s_wdata_T1", sram_wdata, 32'h1234);
        chk("s_addr", {2'd0, sram_addr}, 32'h1);
        chk("s_mfreeze_T1", {31'd0, mem_freeze}, 32'd1);
        tick();
        chk("s_we_T2", {31'd0, sram_we}, 32'd1);
        chk("s_wdata_T2", sram_wdata, 32'h1234);
        tick();
        chk("s_ddone_mfreeze", {31'd0, mem_freeze}, 32'd0);
        chk("s_ddone_req", {31'd0, sram_req}, 32'd0);
        chk("s_rdata_kept", mem_rdata, 32'hC0DE_0040);
        mem_wr_en = 0;
        tick();

        // Flush during FETCH: stale read completes, data dropped, refetch.
        mem_wait = 3; if_req = 1; if_addr = 32'h10;
        tick();
        chk("fl_addr_old", {2'd0, sram_addr}, 32'h4);
        flush = 1; if_addr = 32'h40;
        tick();
        flush = 0;
        chk("fl_drop_req", {31'd0, sram_req}, 32'd1);
        chk("fl_drop_addr", {2'd0, sram_addr}, 32'h4);
        tick(); tick();
        tick();
        chk("fl_idle_req", {31'd0, sram_req}, 32'd0);
        chk("fl_idle_ifreeze", {31'd0, if_freeze}, 32'd1);
        chk("fl_inst_kept", if_inst, 32'hC0DE_0008);
        mem_wait = 0;
        tick();
        chk("fl_new_addr", {2'd0, sram_addr}, 32'h10);
        tick();
        chk("fl_fdone_ifreeze", {31'd0, if_freeze}, 32'd0);
        chk("fl_inst", if_inst, 32'hC0DE_0010);
        if_req = 0;
        tick();

        // Reset during DATA.
        mem_wait = 5; mem_rd_en = 1; mem_addr = 32'h100;
        tick();
        chk("r_data_req", {31'd0, sram_req}, 32'd1);
        tick();
        rst = 1;
        tick();
        chk("r_req", {31'd0, sram_req}, 32'd0);
        chk("r_addr", {2'd0, sram_addr}, 32'd0);
        chk("r_we_wdata", {31'd0, sram_we} | sram_wdata, 32'd0);
        chk("r_inst", if_inst, 32'd0);
        chk("r_rdata", mem_rdata, 32'd0);
        rst = 0; mem_rd_en = 0;
        #1;
        chk("r_freeze", {30'd0, if_freeze, mem_freeze}, 32'd0);
        tick();

        // Zero-wait fetch stream: 2 cycles each with an IDLE gap.
        mem_wait = 0; if_req = 1;
        for (int k = 0; k < 3; k++) begin
            if_addr = 32'(k * 4);
            #1;
            chk("z_idle_req", {31'd0, sram_req}, 32'd0);
            chk("z_idle_ifreeze", {31'd0, if_freeze}, 32'd1);
            tick();
            chk("z_addr", {2'd0, sram_addr}, 32'(k));
            chk("z_fetch_ifreeze", {31'd0, if_freeze}, 32'd1);
            tick();
            chk("z_fdone_ifreeze", {31'd0, if_freeze}, 32'd0);
            chk("z_inst", if_inst, (k == 2) ? 32'hE3A0_0014 : 32'hC0DE_0000 + 32'(k));
            tick();
        end
        if_req = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
